tetromino_bag_queue: RTL
========================

# tetromino_bag_queue

Parametrised successor to the single-slot 7-bag piece generator. It keeps a registered queue of the current piece plus `PREVIEW_DEPTH` upcoming pieces, all drawn from a 7-bag shuffle. It also provides a one-per-drop hold slot. It sits between the game-control FSM (pop/hold requests) and the board/renderer (current piece, preview and hold indices).

## Interface
Parameters:
- `PREVIEW_DEPTH`, default 3: number of upcoming pieces exposed, legal range 1..6.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'hACE1.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pop`  in  1  consume the current piece. Single-cycle request, honoured only while `ready`.
- `hold_req`  in  1  hold/swap the current piece. Honoured only while `ready` and `!hold_used`.
- `ready`  out  1  the queue is full and the outputs are valid.
- `t_out`  out  `tetromino_ctrl`  current piece:
  - `idx` is set from queue slot 0;
  - `tetromino` is filled from the shared shape table;
  - position and rotation are at the package spawn defaults.
- `t_next_out`  out  `tetromino_ctrl`  queue slot 1, built in the same way.
- `preview_idx`  out  `[PREVIEW_DEPTH-1:0][2:0]`  slots 1..`PREVIEW_DEPTH`. Element 0 is the next piece.
- `hold_idx`  out  3  index of the held piece.
- `hold_valid`  out  1  the hold slot is occupied.
- `hold_used`  out  1  a hold has already been used for the current drop.

## Operation
- Indices use `TETROMINO_I_IDX`..`TETROMINO_Z_IDX` (0..6). The value 7 never appears on any output.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  - It advances every cycle while out of reset, whatever the request inputs do.
- Draw (combinational, one per cycle):
  - Candidate `c` = `lfsr[2:0]`, with 7 mapped to 0.
  - If `c` is already used in the current bag, select the first unused index scanning upward from `c` with wrap-around.
  - The chosen index is marked in the 7-bit `bag_used` mask.
  - When a draw would set the 7th bit, `bag_used` is cleared instead, in the same cycle, which starts a new bag.
- FSM states:
  - `FILL`: appends one drawn piece per cycle at the tail. After `PREVIEW_DEPTH+1` draws it moves to `READY`. Requests in `FILL` are ignored.
  - `READY`, on `pop`: the queue shifts by one, slot 0 takes slot 1, a new draw fills the tail, and `hold_used` is cleared.
  - `READY`, on `hold_req` with `!hold_used` and the hold slot empty: the current piece moves to hold, the queue shifts as for a pop, then `hold_valid` and `hold_used` are set.
  - `READY`, on `hold_req` with `!hold_used` and the hold slot full: the current piece and the held piece swap, there is no draw, and `hold_used` is set.
  - `READY`, on `hold_req` with `hold_used` set: no effect.
- Simultaneous `pop` and `hold_req`: the pop wins, the hold is ignored, and `hold_used` is cleared.
- There is no path from `READY` back to `FILL` other than reset.

## Timing
- Reset values:
  - `ready`, `hold_valid` and `hold_used` are 0.
  - All queue slots and `hold_idx` are 0.
  - `t_out` and `t_next_out` are built from index 0 (I piece).
  - `bag_used` is 0 and the LFSR holds `SEED`.
- `ready` rises on the edge that completes the `(PREVIEW_DEPTH+1)`-th draw after `rst_n` deasserts. For the default of 3 this is the 4th rising edge.
- All outputs are registered, including the shape lookup. A request sampled at edge k is visible right after edge k, with no extra latency.
- Throughput: one pop or hold per cycle, sustained.
- Reset mid-`FILL` or mid-operation: all state clears asynchronously and filling restarts from the `SEED` sequence.

## Structure
- Shared package (GLOBAL):
  - `tetromino_ctrl`;
  - the `TETROMINO_*_IDX` constants;
  - the shape table (4 rotations × 4×4);
  - the spawn-default constants;
  - the new `BAG_SIZE = 7`.
- Sub-module `bag_lfsr_draw`: holds the LFSR and `bag_used`. Its input is `draw_en`; its output is `draw_idx`.
- The top level holds the FSM, the queue shift register, the hold logic and the output registers.

## Test plan
- Reset release with the default parameters: `ready` is 0 for 3 edges and 1 after the 4th. `t_out.idx`, `t_next_out.idx` and the preview are all in 0..6, and the first four pieces are distinct.
- 21 back-to-back pops: each consecutive group of 7 emitted `t_out.idx` values is a permutation of 0..6. The sequence matches the bench reference model for `SEED=16'hACE1`.
- `pop` held high during `FILL`: no shift occurs and `ready` timing is unchanged.
- First `hold_req`: `hold_idx` equals the old `t_out.idx`, `t_out.idx` equals the old preview[0], and `hold_valid=hold_used=1`. A second `hold_req` is ignored. After a `pop`, a further `hold_req` swaps the current and held indices with no preview change.
- `pop` and `hold_req` in the same cycle: a pop-only shift occurs, `hold_valid` is unchanged, and `hold_used` is 0.
- `rst_n` pulsed low two cycles into `FILL`: the outputs return to their reset values and, after re-fill, the sequence is identical to the first run.

Source files
------------

// File: rtl/tetromino_bag_queue_pkg.sv
// Shared tetromino definitions: piece indices, shape table, spawn defaults
// and the control record handed to the board and renderer.
package tetromino_bag_queue_pkg;

    localparam int BAG_SIZE = 7;

    localparam logic [2:0] TETROMINO_I_IDX = 3'd0;
    localparam logic [2:0] TETROMINO_J_IDX = 3'd1;
    localparam logic [2:0] TETROMINO_L_IDX = 3'd2;
    localparam logic [2:0] TETROMINO_O_IDX = 3'd3;
    localparam logic [2:0] TETROMINO_S_IDX = 3'd4;
    localparam logic [2:0] TETROMINO_T_IDX = 3'd5;
    localparam logic [2:0] TETROMINO_Z_IDX = 3'd6;

    localparam logic [4:0] SPAWN_X   = 5'd3;
    localparam logic [4:0] SPAWN_Y   = 5'd0;
    localparam logic [1:0] SPAWN_ROT = 2'd0;

    // One 4x4 bitmap per rotation, row-major with bit 15 = row 0 col 0.
    // Element [0] is the spawn rotation.
    typedef logic [3:0][15:0] tetromino_shape_t;

    typedef struct packed {
        logic [2:0]       idx;
        tetromino_shape_t tetromino;
        logic [4:0]       pos_x;
        logic [4:0]       pos_y;
        logic [1:0]       rot;
    } tetromino_ctrl;

    localparam tetromino_shape_t SHAPE_TABLE [0:BAG_SIZE-1] = '{
        {16'h4444, 16'h00F0, 16'h2222, 16'h0F00},   // I
        {16'h44C0, 16'h0E20, 16'h6440, 16'h8E00},   // J
        {16'hC440, 16'h0E80, 16'h4460, 16'h2E00},   // L
        {16'h6600, 16'h6600, 16'h6600, 16'h6600},   // O
        {16'h8C40, 16'h06C0, 16'h4620, 16'h6C00},   // S
        {16'h4C40, 16'h0E40, 16'h4640, 16'h4E00},   // T
        {16'h4C80, 16'h0C60, 16'h2640, 16'hC600}    // Z
    };

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } queue_state_e;

    // Build a spawn-ready control record for a piece index; 7 is never a
    // legal piece so it falls back to the I piece.
    function automatic tetromino_ctrl build_ctrl(input logic [2:0] idx);
        tetromino_ctrl c;
        c.idx       = (idx < 3'd7) ? idx : TETROMINO_I_IDX;
        c.tetromino = SHAPE_TABLE[c.idx];
        c.pos_x     = SPAWN_X;
        c.pos_y     = SPAWN_Y;
        c.rot       = SPAWN_ROT;
        return c;
    endfunction

endpackage

// File: rtl/tetromino_bag_queue_bag_lfsr_draw.sv
// Free-running 16-bit LFSR plus 7-bag bookkeeping. draw_idx is the piece
// that would be taken this cycle; draw_en commits it to the current bag.
module bag_lfsr_draw
    import tetromino_bag_queue_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       draw_en,
    output logic [2:0] draw_idx
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [15:0] lfsr_q, lfsr_d;
    logic [6:0]  bagUsed_q, bagUsed_d;
    logic [6:0]  bagMarked;
    logic [2:0]  cand;
    logic [2:0]  pick;
    logic [3:0]  scanPos;
    logic        found;

    // Candidate from the LFSR, then scan upward with wrap for the first
    // piece not yet dealt in this bag.
    always_comb begin
        cand    = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
        pick    = cand;
        found   = 1'b0;
        scanPos = 4'd0;
        for (int k = 0; k < BAG_SIZE; k++) begin
            scanPos = {1'b0, cand} + 4'(k);
            if (scanPos >= 4'd7) begin
                scanPos = scanPos - 4'd7;
            end
            if (!found && !bagUsed_q[scanPos[2:0]]) begin
                pick  = scanPos[2:0];
                found = 1'b1;
            end
        end
    end

    // Next LFSR value and bag mask; the seventh piece empties the bag at once.
    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        bagMarked = bagUsed_q | (7'b1 << pick);
        bagUsed_d = bagUsed_q;
        if (draw_en) begin
            bagUsed_d = (bagMarked == 7'h7F) ? 7'h00 : bagMarked;
        end
    end

    // LFSR steps every cycle regardless of requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q    <= SEED_EFF;
            bagUsed_q <= 7'h00;
        end else begin
            lfsr_q    <= lfsr_d;
            bagUsed_q <= bagUsed_d;
        end
    end

    assign draw_idx = pick;

endmodule

// File: rtl/tetromino_bag_queue.sv
// Current piece + preview queue fed from a 7-bag shuffle, with a
// one-per-drop hold slot. All outputs come straight from registers.
module tetromino_bag_queue
    import tetromino_bag_queue_pkg::*;
#(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pop,
    input  logic                          hold_req,
    output logic                          ready,
    output tetromino_ctrl                 t_out,
    output tetromino_ctrl                 t_next_out,
    output logic [PREVIEW_DEPTH-1:0][2:0] preview_idx,
    output logic [2:0]                    hold_idx,
    output logic                          hold_valid,
    output logic                          hold_used
);

    localparam int         SLOTS     = PREVIEW_DEPTH + 1;
    localparam logic [2:0] LAST_FILL = 3'(PREVIEW_DEPTH);

    queue_state_e              state_q, state_d;
    logic [SLOTS-1:0][2:0]     slots_q, slots_d;
    logic [2:0]                fillCnt_q, fillCnt_d;
    logic [2:0]                holdIdx_q, holdIdx_d;
    logic                      holdValid_q, holdValid_d;
    logic                      holdUsed_q, holdUsed_d;
    logic                      ready_q;
    tetromino_ctrl             tOut_q, tNextOut_q;
    logic                      drawEn;
    logic [2:0]                drawIdx;

    bag_lfsr_draw #(
        .SEED (SEED)
    ) u_draw (
        .clk      (clk),
        .rst_n    (rst_n),
        .draw_en  (drawEn),
        .draw_idx (drawIdx)
    );

    // Fill/serve FSM together with the queue, hold and draw-request decisions.
    always_comb begin
        state_d     = state_q;
        slots_d     = slots_q;
        fillCnt_d   = fillCnt_q;
        holdIdx_d   = holdIdx_q;
        holdValid_d = holdValid_q;
        holdUsed_d  = holdUsed_q;
        drawEn      = 1'b0;
        case (state_q)
            FILL: begin
                drawEn = 1'b1;
                for (int i = 0; i < SLOTS; i++) begin
                    if (fillCnt_q == 3'(i)) begin
                        slots_d[i] = drawIdx;
                    end
                end
                if (fillCnt_q == LAST_FILL) begin
                    state_d = READY;
                end else begin
                    fillCnt_d = fillCnt_q + 3'd1;
                end
            end
            READY: begin
                if (pop) begin
                    drawEn = 1'b1;
                    for (int i = 0; i < SLOTS - 1; i++) begin
                        slots_d[i] = slots_q[i+1];
                    end
                    slots_d[SLOTS-1] = drawIdx;
                    holdUsed_d       = 1'b0;
                end else if (hold_req && !holdUsed_q) begin
                    holdIdx_d  = slots_q[0];
                    holdUsed_d = 1'b1;
                    if (!holdValid_q) begin
                        drawEn = 1'b1;
                        for (int i = 0; i < SLOTS - 1; i++) begin
                            slots_d[i] = slots_q[i+1];
                        end
                        slots_d[SLOTS-1] = drawIdx;
                        holdValid_d      = 1'b1;
                    end else begin
                        slots_d[0] = holdIdx_q;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers and the registered output records built from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            slots_q     <= '0;
            fillCnt_q   <= 3'd0;
            holdIdx_q   <= 3'd0;
            holdValid_q <= 1'b0;
            holdUsed_q  <= 1'b0;
            ready_q     <= 1'b0;
            tOut_q      <= build_ctrl(TETROMINO_I_IDX);
            tNextOut_q  <= build_ctrl(TETROMINO_I_IDX);
        end else begin
            state_q     <= state_d;
            slots_q     <= slots_d;
            fillCnt_q   <= fillCnt_d;
            holdIdx_q   <= holdIdx_d;
            holdValid_q <= holdValid_d;
            holdUsed_q  <= holdUsed_d;
            ready_q     <= (state_d == READY);
            tOut_q      <= build_ctrl(slots_d[0]);
            tNextOut_q  <= build_ctrl(slots_d[1]);
        end
    end

    assign ready       = ready_q;
    assign t_out       = tOut_q;
    assign t_next_out  = tNextOut_q;
    assign preview_idx = slots_q[PREVIEW_DEPTH:1];
    assign hold_idx    = holdIdx_q;
    assign hold_valid  = holdValid_q;
    assign hold_used   = holdUsed_q;

endmodule
